// File: rtl/uart_tx_arbiter_if.sv
// Handshake and configuration bundle between the requesters, the arbiter and
// the shared uart_tx transmitter. The arbiter takes the slave view.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   done;
    logic [19:0]          cfg_timeout;
    logic [7:0]           cfg_gap;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 err_timeout;

    modport master (
        output req_valid, req_data, cfg_timeout, cfg_gap, tx_done,
        input  req_ready, done, tx_start, tx_data, grant_id, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_data, cfg_timeout, cfg_gap, tx_done,
        output req_ready, done, tx_start, tx_data, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// One byte is granted per frame; the arbiter then waits for tx_done (or a
// timeout) and optionally idles for a configurable gap before re-arbitrating.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [19:0]          tcnt_q, tcnt_d;
    logic [19:0]          tmo_q, tmo_d;
    logic [7:0]           gcnt_q, gcnt_d;
    logic [7:0]           gap_q, gap_d;

    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 found_hi, found_lo, any_req;
    logic [IDW-1:0]       win_hi, win_lo, winner;

    // Round-robin pick: lowest valid index above ptr, else lowest valid index
    // at or below ptr (equivalent to searching from ptr+1 with wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[IDW'(i)]) begin
                if (IDW'(i) > ptr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        win_hi   = IDW'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = IDW'(i);
                end
            end
        end
        any_req = found_hi | found_lo;
        winner  = found_hi ? win_hi : win_lo;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tcnt_d     = tcnt_q;
        tmo_d      = tmo_q;
        gcnt_d     = gcnt_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        ready_d    = '0;
        done_d     = '0;
        grant_d    = grant_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    tx_start_d      = 1'b1;
                    tx_data_d       = bus.req_data[{winner, 3'b000} +: 8];
                    ready_d[winner] = 1'b1;
                    grant_d         = winner;
                    ptr_d           = winner;
                    tmo_d           = bus.cfg_timeout;
                    gap_d           = bus.cfg_gap;
                    tcnt_d          = '0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 20'd1;
                end
                // tx_done takes precedence over a coincident timeout
                if (bus.tx_done || (tmo_q != '0 && tcnt_q == tmo_q - 20'd1)) begin
                    if (bus.tx_done) begin
                        done_d[grant_q] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    gcnt_d  = '0;
                    state_d = (gap_q != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gcnt_q == gap_q - 8'd1) begin
                    gcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NUM_REQ - 1);
            tcnt_q     <= '0;
            tmo_q      <= '0;
            gcnt_q     <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ready_q    <= '0;
            done_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tcnt_q     <= tcnt_d;
            tmo_q      <= tmo_d;
            gcnt_q     <= gcnt_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.req_ready   = ready_q;
    assign bus.done        = done_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ = 4).
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   bad;
    int   id;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start();
        for (int n = 0; n < 20 && bus.tx_start !== 1'b1; n++) step();
        chk("start_seen", 32'(bus.tx_start), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_tx_data"},  32'(bus.tx_data), 32'd0);
        chk({tag, "_ready"},    32'(bus.req_ready), 32'd0);
        chk({tag, "_done"},     32'(bus.done), 32'd0);
        chk({tag, "_grant"},    32'(bus.grant_id), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy), 32'd0);
        chk({tag, "_err"},      32'(bus.err_timeout), 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.cfg_timeout = '0;
        bus.cfg_gap     = '0;
        bus.tx_done     = 1'b0;

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk_all_zero("idle_after_reset");

        // Single request from requester 2, byte A5
        bus.req_data  = 32'h00A5_0000;
        bus.req_valid = 4'b0100;
        step();
        chk("single_tx_start", 32'(bus.tx_start), 32'd1);
        chk("single_tx_data",  32'(bus.tx_data), 32'hA5);
        chk("single_ready",    32'(bus.req_ready), 32'b0100);
        chk("single_grant",    32'(bus.grant_id), 32'd2);
        chk("single_busy",     32'(bus.busy), 32'd1);
        bus.req_valid = '0;
        step();
        chk("single_start_pulse", 32'(bus.tx_start), 32'd0);
        chk("single_ready_pulse", 32'(bus.req_ready), 32'd0);
        repeat (28) step();
        chk("single_no_early_done", 32'(bus.done), 32'd0);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("single_done", 32'(bus.done), 32'b0100);
        chk("single_idle", 32'(bus.busy), 32'd0);
        step();
        chk("single_done_pulse", 32'(bus.done), 32'd0);

        // Spurious tx_done in IDLE
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("spur_done",  32'(bus.done), 32'd0);
        chk("spur_start", 32'(bus.tx_start), 32'd0);
        chk("spur_busy",  32'(bus.busy), 32'd0);
        chk("spur_grant", 32'(bus.grant_id), 32'd2);
        chk("spur_data",  32'(bus.tx_data), 32'hA5);

        // Reset in the middle of WAIT (requester 3 follows pointer 2)
        bus.req_data  = 32'h4433_2211;
        bus.req_valid = 4'b1000;
        step();
        chk("pre_rst_grant", 32'(bus.grant_id), 32'd3);
        bus.req_valid = '0;
        step();
        step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.req_valid = 4'b1111;
        bus.tx_done   = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.err_timeout !== 1'b0) bad++;
        end
        chk("rst_hold_quiet", 32'(bad), 32'd0);
        rst_n       = 1'b1;
        bus.tx_done = 1'b0;
        #1;
        chk("rel_start", 32'(bus.tx_start), 32'd0);
        chk("rel_busy",  32'(bus.busy), 32'd0);

        // Round robin with all requesters valid: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            wait_start();
            chk("rr_grant", 32'(bus.grant_id), 32'(id));
            chk("rr_data",  32'(bus.tx_data), 32'h11 * 32'(id + 1));
            chk("rr_ready", 32'(bus.req_ready), 32'd1 << id);
            if (k == 4) bus.req_valid = '0;
            step();
            chk("rr_ready_pulse", 32'(bus.req_ready), 32'd0);
            chk("rr_start_pulse", 32'(bus.tx_start), 32'd0);
            bus.tx_done = 1'b1;
            step();
            bus.tx_done = 1'b0;
            chk("rr_done", 32'(bus.done), 32'd1 << id);
        end

        // Gap of 5 cycles; request raised during GAP is held off
        bus.cfg_gap   = 8'd5;
        bus.req_valid = 4'b0010;
        step();
        chk("gap_grant", 32'(bus.grant_id), 32'd1);
        bus.req_valid = '0;
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("gap_done", 32'(bus.done), 32'b0010);
        chk("gap_busy0", 32'(bus.busy), 32'd1);
        bus.req_valid = 4'b0001;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) bad++;
        end
        chk("gap_hold", 32'(bad), 32'd0);
        step();
        chk("gap_end_busy",  32'(bus.busy), 32'd0);
        chk("gap_end_start", 32'(bus.tx_start), 32'd0);
        bus.cfg_gap = 8'd0;
        step();
        chk("gap_next_start", 32'(bus.tx_start), 32'd1);
        chk("gap_next_grant", 32'(bus.grant_id), 32'd0);
        chk("gap_next_ready", 32'(bus.req_ready), 32'b0001);

        // Zero gap: next start one cycle after done
        bus.req_valid = '0;
        step();
        bus.tx_done   = 1'b1;
        bus.req_valid = 4'b0100;
        step();
        bus.tx_done = 1'b0;
        chk("nogap_done", 32'(bus.done), 32'b0001);
        chk("nogap_busy", 32'(bus.busy), 32'd0);
        step();
        chk("nogap_start", 32'(bus.tx_start), 32'd1);
        chk("nogap_grant", 32'(bus.grant_id), 32'd2);
        bus.req_valid = '0;
        step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("nogap_done2", 32'(bus.done), 32'b0100);

        // Timeout of 100 cycles without tx_done
        bus.cfg_timeout = 20'd100;
        bus.req_valid   = 4'b1000;
        step();
        chk("tmo_grant", 32'(bus.grant_id), 32'd3);
        bus.req_valid = '0;
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (bus.err_timeout !== 1'b0 || bus.done !== 4'b0000) bad++;
        end
        chk("tmo_quiet", 32'(bad), 32'd0);
        step();
        chk("tmo_err",  32'(bus.err_timeout), 32'd1);
        chk("tmo_done", 32'(bus.done), 32'd0);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
        step();
        chk("tmo_err_pulse", 32'(bus.err_timeout), 32'd0);

        // tx_done on the terminal timeout cycle wins; pointer wraps 3 -> 0
        bus.req_valid = 4'b0001;
        step();
        chk("race_grant", 32'(bus.grant_id), 32'd0);
        bus.req_valid = '0;
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            if (bus.err_timeout !== 1'b0) bad++;
        end
        chk("race_quiet", 32'(bad), 32'd0);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("race_done", 32'(bus.done), 32'b0001);
        chk("race_err",  32'(bus.err_timeout), 32'd0);
        step();
        chk("race_err_late", 32'(bus.err_timeout), 32'd0);
        chk("race_idle",     32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
